// File: rtl/rob_retire_ctrl_if.sv
// Retire controller bundle: ROB head view in, retire/commit/RF/redirect out.
// master = ROB / upstream side, slave = retire controller.
// Optional retired_count exists only with ROB_RETIRE_STATS_EN defined.
interface rob_retire_ctrl_if #(
  parameter int DEPTHLOG2 = 4,
  parameter int EXT_COUNT = 2
);
  logic                               rob_empty;
  logic [DEPTHLOG2:0]                 rob_used_count;
  logic [EXT_COUNT-1:0]               slot_valid;
  logic [EXT_COUNT-1:0][4:0]          slot_dest_reg;
  logic [EXT_COUNT-1:0]               slot_dest_valid;
  logic [EXT_COUNT-1:0][31:0]         slot_result;
  logic [EXT_COUNT-1:0]               slot_is_store;
  logic [EXT_COUNT-1:0]               slot_exc;
  logic [EXT_COUNT-1:0][31:0]         slot_pc;
  logic                               store_stall;

  logic                               consume;
  logic                               consume_count;
  logic                               store_commit;
  logic [EXT_COUNT-1:0]               rf_we;
  logic [EXT_COUNT-1:0][4:0]          rf_waddr;
  logic [EXT_COUNT-1:0][31:0]         rf_wdata;
  logic                               retire_busy;
  logic                               redirect;
  logic [31:0]                        redirect_pc;
`ifdef ROB_RETIRE_STATS_EN
  logic [31:0]                        retired_count;
`endif

  modport master (
    output rob_empty, rob_used_count, slot_valid, slot_dest_reg, slot_dest_valid,
           slot_result, slot_is_store, slot_exc, slot_pc, store_stall,
    input  consume, consume_count, store_commit, rf_we, rf_waddr, rf_wdata,
           retire_busy, redirect, redirect_pc
`ifdef ROB_RETIRE_STATS_EN
    , input retired_count
`endif
  );

  modport slave (
    input  rob_empty, rob_used_count, slot_valid, slot_dest_reg, slot_dest_valid,
           slot_result, slot_is_store, slot_exc, slot_pc, store_stall,
    output consume, consume_count, store_commit, rf_we, rf_waddr, rf_wdata,
           retire_busy, redirect, redirect_pc
`ifdef ROB_RETIRE_STATS_EN
    , output retired_count
`endif
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// ROB retire controller: retires up to two head entries per cycle in order,
// writes results to the RF one cycle later, commits stores, and on an
// exception at the head drains the ROB and issues a one-cycle redirect.
// Optional feature: define ROB_RETIRE_STATS_EN to add retired_count.
// Only EXT_COUNT == 2 is supported.

// Per-lane RF write stage: registers the write for a retiring slot.
module rob_retire_lane (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        retire_i,
  input  logic        exc_i,
  input  logic        dest_valid_i,
  input  logic [4:0]  dest_reg_i,
  input  logic [31:0] result_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);
  logic        we_d;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  // x0 is hardwired, excepting slots never update architectural state
  assign we_d = retire_i && !exc_i && dest_valid_i && (dest_reg_i != 5'd0);

  // RF write port register; address/data hold when no write is issued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        waddr_q <= dest_reg_i;
        wdata_q <= result_i;
      end
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
endmodule

module rob_retire_ctrl #(
  parameter int DEPTHLOG2 = 4,
  parameter int EXT_COUNT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  rob_retire_ctrl_if.slave bus
);
  localparam int UW = DEPTHLOG2 + 1;
  localparam logic [UW-1:0] CNT_ONE = UW'(1);
  localparam logic [UW-1:0] CNT_TWO = UW'(2);

  typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] epc_q;

  logic                 r0, r1;
  logic                 consume, consume_cnt, store_commit;
  logic                 drain_done;
  logic [UW-1:0]        n_consumed;
  logic [EXT_COUNT-1:0] retire;
  logic [EXT_COUNT-1:0]        rf_we;
  logic [EXT_COUNT-1:0][4:0]   rf_waddr;
  logic [EXT_COUNT-1:0][31:0]  rf_wdata;

  logic        used_ge2;
  assign used_ge2 = (bus.rob_used_count >= CNT_TWO);

  // Retire decision for the current head pair, per FSM state
  always_comb begin
    r0           = 1'b0;
    r1           = 1'b0;
    consume      = 1'b0;
    consume_cnt  = 1'b0;
    store_commit = 1'b0;
    retire       = '0;
    n_consumed   = '0;
    drain_done   = 1'b0;
    case (state_q)
      RUN: begin
        r0 = !bus.rob_empty && bus.slot_valid[0]
             && !(bus.slot_is_store[0] && bus.store_stall);
        // Pairing only for clean slots; store buffer takes one store a cycle
        r1 = r0 && !bus.slot_exc[0] && !bus.slot_exc[1] && bus.slot_valid[1]
             && used_ge2 && !(bus.slot_is_store[0] && bus.slot_is_store[1])
             && !(bus.slot_is_store[1] && bus.store_stall);
        consume      = r0;
        consume_cnt  = r1;
        store_commit = (r0 && !bus.slot_exc[0] && bus.slot_is_store[0])
                       || (r1 && bus.slot_is_store[1]);
        retire       = {r1, r0};
      end
      DRAIN: begin
        // Squash written entries; nothing reaches RF or store buffer
        consume     = !bus.rob_empty && bus.slot_valid[0];
        consume_cnt = bus.slot_valid[1] && used_ge2;
        if (consume) n_consumed = consume_cnt ? CNT_TWO : CNT_ONE;
        drain_done  = bus.rob_empty || (n_consumed == bus.rob_used_count);
      end
      default: ;
    endcase
  end

  // Retire FSM with registered busy/redirect outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      busy_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      epc_q         <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (r0 && bus.slot_exc[0]) begin
            epc_q   <= bus.slot_pc[0];
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q       <= REDIRECT;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
          end
        end
        REDIRECT: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One RF write lane per examined head slot
  for (genvar g = 0; g < EXT_COUNT; g++) begin : g_lane
    rob_retire_lane u_lane (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .retire_i     (retire[g]),
      .exc_i        (bus.slot_exc[g]),
      .dest_valid_i (bus.slot_dest_valid[g]),
      .dest_reg_i   (bus.slot_dest_reg[g]),
      .result_i     (bus.slot_result[g]),
      .we_o         (rf_we[g]),
      .waddr_o      (rf_waddr[g]),
      .wdata_o      (rf_wdata[g])
    );
  end

`ifdef ROB_RETIRE_STATS_EN
  logic [31:0] retired_q;
  logic [31:0] retired_d;

  // Count every retirement outside DRAIN, excepting slots included
  always_comb begin
    retired_d = retired_q;
    if (state_q != DRAIN && consume)
      retired_d = retired_q + (consume_cnt ? 32'd2 : 32'd1);
  end

  // Free-running retirement counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign bus.retired_count = retired_q;
`endif

  // Only slot0 can raise the redirect, so slot1's PC is not needed here
  logic unused_pc1;
  assign unused_pc1 = ^bus.slot_pc[1];

  assign bus.consume       = consume;
  assign bus.consume_count = consume_cnt;
  assign bus.store_commit  = store_commit;
  assign bus.rf_we         = rf_we;
  assign bus.rf_waddr      = rf_waddr;
  assign bus.rf_wdata      = rf_wdata;
  assign bus.retire_busy   = busy_q;
  assign bus.redirect      = redirect_q;
  assign bus.redirect_pc   = redirect_pc_q;
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl with an RF-write scoreboard.
module tb_rob_retire_ctrl;
  localparam int DL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_retire_ctrl_if #(.DEPTHLOG2(DL), .EXT_COUNT(2)) bus ();
  rob_retire_ctrl #(.DEPTHLOG2(DL), .EXT_COUNT(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
  } rfexp_t;

  rfexp_t      sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic        busy_model;
  logic [31:0] ret_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    bus.slot_valid      = '0;
    bus.slot_dest_reg   = '0;
    bus.slot_dest_valid = '0;
    bus.slot_result     = '0;
    bus.slot_is_store   = '0;
    bus.slot_exc        = '0;
    bus.slot_pc         = '0;
    bus.store_stall     = 1'b0;
    bus.rob_empty       = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic v, input logic dv, input logic [4:0] r,
                          input logic [31:0] res, input logic st, input logic exc,
                          input logic [31:0] pc);
    bus.slot_valid[i]      = v;
    bus.slot_dest_valid[i] = dv;
    bus.slot_dest_reg[i]   = r;
    bus.slot_result[i]     = res;
    bus.slot_is_store[i]   = st;
    bus.slot_exc[i]        = exc;
    bus.slot_pc[i]         = pc;
  endtask

  // Check combinational retire outputs, queue the expected RF write, clock,
  // then compare the registered outputs.
  task automatic step(input string tag, input logic ec, input logic ecc, input logic esc,
                      input logic ebusy, input logic eredir);
    rfexp_t e;
    #1;
    chk({tag, ".consume"}, 64'(bus.consume), 64'(ec));
    chk({tag, ".consume_count"}, 64'(bus.consume_count), 64'(ecc));
    chk({tag, ".store_commit"}, 64'(bus.store_commit), 64'(esc));
    e = '0;
    if (!busy_model && ec) begin
      if (!bus.slot_exc[0] && bus.slot_dest_valid[0] && bus.slot_dest_reg[0] != 5'd0) begin
        e.we[0] = 1'b1; e.a0 = bus.slot_dest_reg[0]; e.d0 = bus.slot_result[0];
      end
      if (ecc && !bus.slot_exc[1] && bus.slot_dest_valid[1] && bus.slot_dest_reg[1] != 5'd0) begin
        e.we[1] = 1'b1; e.a1 = bus.slot_dest_reg[1]; e.d1 = bus.slot_result[1];
      end
      ret_model = ret_model + (ecc ? 32'd2 : 32'd1);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".rf_we"}, 64'(bus.rf_we), 64'(e.we));
    if (e.we[0]) begin
      chk({tag, ".rf_waddr0"}, 64'(bus.rf_waddr[0]), 64'(e.a0));
      chk({tag, ".rf_wdata0"}, 64'(bus.rf_wdata[0]), 64'(e.d0));
    end
    if (e.we[1]) begin
      chk({tag, ".rf_waddr1"}, 64'(bus.rf_waddr[1]), 64'(e.a1));
      chk({tag, ".rf_wdata1"}, 64'(bus.rf_wdata[1]), 64'(e.d1));
    end
    chk({tag, ".retire_busy"}, 64'(bus.retire_busy), 64'(ebusy));
    chk({tag, ".redirect"}, 64'(bus.redirect), 64'(eredir));
`ifdef ROB_RETIRE_STATS_EN
    chk({tag, ".retired_count"}, 64'(bus.retired_count), 64'(ret_model));
`endif
    busy_model = ebusy;
  endtask

  initial begin
    rst = 1'b1;
    busy_model = 1'b0;
    ret_model  = '0;
    clear_slots();
    bus.rob_empty      = 1'b1;
    bus.rob_used_count = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst.rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst.rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst.busy", 64'(bus.retire_busy), 64'd0);
    chk("rst.redirect", 64'(bus.redirect), 64'd0);
    chk("rst.redirect_pc", 64'(bus.redirect_pc), 64'd0);
    chk("rst.consume", 64'(bus.consume), 64'd0);
    rst = 1'b0;

    // Dual ALU retire
    clear_slots(); bus.rob_used_count = 2;
    set_slot(0, 1, 1, 5'd3, 32'h11, 0, 0, 32'h100);
    set_slot(1, 1, 1, 5'd4, 32'h22, 0, 0, 32'h104);
    step("alu2", 1, 1, 0, 0, 0);

    // Two stores: one per cycle
    clear_slots(); bus.rob_used_count = 2;
    set_slot(0, 1, 0, 5'd0, 32'h0, 1, 0, 32'h108);
    set_slot(1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h10c);
    step("st2a", 1, 0, 1, 0, 0);
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 0, 5'd0, 32'h0, 1, 0, 32'h10c);
    step("st2b", 1, 0, 1, 0, 0);

    // Store stalled at slot0 blocks everything
    clear_slots(); bus.rob_used_count = 1; bus.store_stall = 1'b1;
    set_slot(0, 1, 0, 5'd0, 32'h0, 1, 0, 32'h110);
    step("stall0", 0, 0, 0, 0, 0);

    // Store stalled at slot1: ALU at slot0 retires alone
    clear_slots(); bus.rob_used_count = 2; bus.store_stall = 1'b1;
    set_slot(0, 1, 1, 5'd6, 32'h66, 0, 0, 32'h110);
    set_slot(1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h114);
    step("stall1", 1, 0, 0, 0, 0);

    // Destination x0 never written
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 1, 5'd0, 32'h55, 0, 0, 32'h118);
    step("x0", 1, 0, 0, 0, 0);

    // used_count == 1 forbids pairing even with both slots valid
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 1, 5'd8, 32'h88, 0, 0, 32'h11c);
    set_slot(1, 1, 1, 5'd9, 32'h99, 0, 0, 32'h120);
    step("used1", 1, 0, 0, 0, 0);

    // Empty ROB
    clear_slots(); bus.rob_empty = 1'b1; bus.rob_used_count = 0;
    set_slot(0, 1, 1, 5'd8, 32'h88, 0, 0, 32'h11c);
    step("empty", 0, 0, 0, 0, 0);

    // Exception at slot1: slot0 retires alone, then exception as slot0
    clear_slots(); bus.rob_used_count = 2;
    set_slot(0, 1, 1, 5'd5, 32'h77, 0, 0, 32'h200);
    set_slot(1, 1, 1, 5'd10, 32'h99, 0, 1, 32'h800);
    step("exc1a", 1, 0, 0, 0, 0);
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 1, 5'd10, 32'h99, 0, 1, 32'h800);
    step("exc1b", 1, 0, 0, 1, 0);
    clear_slots(); bus.rob_empty = 1'b1; bus.rob_used_count = 0;
    step("drainE", 0, 0, 0, 1, 1);
    chk("drainE.redirect_pc", 64'(bus.redirect_pc), 64'h800);
    step("redir800", 0, 0, 0, 0, 0);

    // Exception at slot0, three younger entries drained over four cycles
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 1, 5'd12, 32'hc, 0, 1, 32'h400);
    step("exc0", 1, 0, 0, 1, 0);
    clear_slots(); bus.rob_used_count = 3;
    step("d1", 0, 0, 0, 1, 0);
    clear_slots(); bus.rob_used_count = 3; bus.store_stall = 1'b1;
    set_slot(0, 1, 1, 5'd13, 32'haa, 1, 0, 32'h404);
    step("d2", 1, 0, 0, 1, 0);
    clear_slots(); bus.rob_used_count = 2;
    step("d3", 0, 0, 0, 1, 0);
    clear_slots(); bus.rob_used_count = 2;
    set_slot(0, 1, 1, 5'd14, 32'hbb, 0, 0, 32'h408);
    set_slot(1, 1, 1, 5'd15, 32'hcc, 0, 0, 32'h40c);
    step("d4", 1, 1, 0, 1, 1);
    chk("d4.redirect_pc", 64'(bus.redirect_pc), 64'h400);
    clear_slots(); bus.rob_empty = 1'b1; bus.rob_used_count = 0;
    step("d5", 0, 0, 0, 0, 0);
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 1, 5'd2, 32'h1234, 0, 0, 32'h500);
    step("post", 1, 0, 0, 0, 0);

    // Reset in the middle of a drain
    clear_slots(); bus.rob_used_count = 1;
    set_slot(0, 1, 0, 5'd0, 32'h0, 0, 1, 32'h600);
    step("rexc", 1, 0, 0, 1, 0);
    clear_slots(); bus.rob_used_count = 3;
    step("rd1", 0, 0, 0, 1, 0);
    rst = 1'b1;
    #1;
    ret_model  = '0;
    busy_model = 1'b0;
    chk("rmid.busy", 64'(bus.retire_busy), 64'd0);
    chk("rmid.redirect", 64'(bus.redirect), 64'd0);
    chk("rmid.redirect_pc", 64'(bus.redirect_pc), 64'd0);
`ifdef ROB_RETIRE_STATS_EN
    chk("rmid.retired_count", 64'(bus.retired_count), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    clear_slots(); bus.rob_empty = 1'b1; bus.rob_used_count = 0;
    step("rst1", 0, 0, 0, 0, 0);
    step("rst2", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rob_retire_ctrl.md
ROB_RETIRE_CTRL -- requirements
Module: rob_retire_ctrl

Interface
REQ-001 SHALL have parameter DEPTHLOG2, default 4, log2 of the ROB depth. The ROB used-count port is DEPTHLOG2+1 bits wide.
REQ-002 SHALL have parameter EXT_COUNT, default 2, ROB head slots examined per cycle. Only the value 2 is supported.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rob_empty  in  1  ROB holds no entries.
REQ-006 rob_used_count  in  DEPTHLOG2+1  number of occupied ROB entries.
REQ-007 slot_valid  in  1 x2  head slot i has its result written.
REQ-008 slot_dest_reg  in  5 x2  destination register of slot i.
REQ-009 slot_dest_valid  in  1 x2  slot i writes a register.
REQ-010 slot_result  in  32 x2  result value of slot i.
REQ-011 slot_is_store  in  1 x2  slot i is a store.
REQ-012 slot_exc  in  1 x2  slot i raised an exception.
REQ-013 slot_pc  in  32 x2  PC of slot i.
REQ-014 store_stall  in  1  store buffer cannot accept a store this cycle.
REQ-015 consume  out  1  combinational; retire head entries at the next edge.
REQ-016 consume_count  out  1  combinational; 0 = one entry, 1 = two entries.
REQ-017 store_commit  out  1  combinational; a store retires this cycle.
REQ-018 rf_we  out  1 x2  registered register-file write enables.
REQ-019 rf_waddr  out  5 x2  registered register-file write addresses.
REQ-020 rf_wdata  out  32 x2  registered register-file write data.
REQ-021 retire_busy  out  1  registered; high whenever state is not RUN (upstream stalls ROB reservation).
REQ-022 redirect  out  1  registered one-cycle pulse to refetch.
REQ-023 redirect_pc  out  32  registered exception PC.

Function
REQ-024 SHALL implement FSM states RUN, DRAIN, REDIRECT.
REQ-025 In RUN, slot0 retirable SHALL equal: !rob_empty && slot_valid[0] && !(slot_is_store[0] && store_stall).
REQ-026 In RUN, slot1 retirable SHALL require all of:
- slot0 retirable;
- !slot_exc[0] and !slot_exc[1];
- slot_valid[1];
- rob_used_count >= 2;
- not both slots are stores;
- !(slot_is_store[1] && store_stall).
REQ-027 consume SHALL equal slot0 retirable; consume_count SHALL equal slot1 retirable. Retirement is strictly in order.
REQ-028 A retiring slot with slot_exc=0, slot_dest_valid=1 and slot_dest_reg!=0 SHALL produce rf_we/rf_waddr/rf_wdata for that slot one cycle after consume. Otherwise rf_we for that slot is 0 in that cycle.
REQ-029 store_commit SHALL be 1 when a retiring non-excepting slot has slot_is_store=1. Excepting slots never assert store_commit.
REQ-030 Exception at slot0: SHALL consume slot0 alone, with no rf write and no store_commit, latch slot_pc[0], and enter DRAIN.
REQ-031 Exception at slot1 only: SHALL retire slot0 alone; slot1 is handled as slot0 in a later cycle.
REQ-032 In DRAIN, SHALL discard written head entries: consume=1 when !rob_empty && slot_valid[0]. consume_count follows slot_valid[1] && rob_used_count>=2. No rf writes, no store_commit, store_stall ignored.
REQ-033 In DRAIN, the FSM SHALL move to REDIRECT in the cycle where rob_empty=1, or where the entries being consumed equal rob_used_count.
REQ-034 REDIRECT SHALL last one cycle with redirect=1 and redirect_pc=latched PC, then return to RUN.
REQ-035 The rob_used_count comparisons SHALL be unsigned at DEPTHLOG2+1 bits.

Reset
REQ-036 While reset is high, SHALL force state=RUN; rf_we, redirect and retire_busy to 0; rf_waddr, rf_wdata, redirect_pc and the latched PC to 0.
REQ-037 Reset asserted mid-DRAIN SHALL abandon the drain. No redirect pulse is emitted afterwards.

Configuration
REQ-038 With macro ROB_RETIRE_STATS_EN defined, SHALL add output retired_count (32 bits, reset 0). It increments by 1 or 2 per non-DRAIN retirement, including excepting slots, and wraps modulo 2^32.
REQ-039 Without ROB_RETIRE_STATS_EN, retired_count and its counter SHALL be absent. All other behaviour is unchanged.

Verification
REQ-040 Two valid ALU entries (dest 3 = 0x11, dest 4 = 0x22), used_count 2 -> consume=1, consume_count=1. Next cycle rf_we=11, addresses 3/4, data 0x11/0x22.
REQ-041 Two valid stores with store_stall=0 -> consume_count=0 and store_commit=1; the second store retires the next cycle.
REQ-042 Slot0 with dest_reg=0 retires -> rf_we[0]=0.
REQ-043 slot_exc[0]=1 at pc 0x400, then 3 more entries that become valid over 4 cycles -> retire_busy=1, all 3 discarded, redirect=1 for exactly one cycle with redirect_pc=0x400, then RUN.
REQ-044 slot_valid[0]=1, slot_exc[1]=1 -> only slot0 retires; the following cycle enters DRAIN.
REQ-045 Reset pulse during DRAIN -> state RUN, redirect never asserted. With ROB_RETIRE_STATS_EN, retired_count=0.
